// File: rtl/sample_serializer.sv
// Round-robin multi-channel sample-to-byte serializer; first byte 3 cycles after arbitration, 1 byte/clk under ack.
// data_rdy holds data and byte index until data_ack; sample_rdy is only consulted in IDLE and on the final-byte ack.
module sample_serializer #(
  parameter int SAMPLE_BYTES = 6,
  parameter int N_CHANNELS   = 2,
  parameter int TAG_EN       = 0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [N_CHANNELS*SAMPLE_BYTES*8-1:0] sample,
  input  logic [N_CHANNELS-1:0]                sample_rdy,
  output logic [N_CHANNELS-1:0]                sample_req,
  output logic [7:0]                           data,
  output logic                                 data_rdy,
  input  logic                                 data_ack,
  output logic [2:0]                           channel
);

  localparam int SW          = SAMPLE_BYTES * 8;
  localparam int FRAME_BYTES = SAMPLE_BYTES + ((TAG_EN != 0) ? 1 : 0);
  localparam int FW          = FRAME_BYTES * 8;
  localparam int IDX_W       = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam int PTR_W       = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;

  typedef enum logic [1:0] {IDLE, REQ, LOAD, SEND} state_t;

  state_t           state;
  logic [PTR_W-1:0] grant;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] ptr_after;
  logic [PTR_W-1:0] pick_idle;
  logic [PTR_W-1:0] pick_next;
  logic [IDX_W-1:0] idx;
  logic [FW-1:0]    shadow;
  logic [FW-1:0]    frame_new;
  logic [SW-1:0]    slice;
  logic [7:0]       tag_byte;

  // First requesting channel at or after ptr, scanning upward with wrap.
  function automatic logic [PTR_W-1:0] pick(input logic [N_CHANNELS-1:0] rdy,
                                            input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] best;
    int               best_d;
    int               d;
    best   = ptr;
    best_d = N_CHANNELS;
    for (int j = 0; j < N_CHANNELS; j++) begin
      d = (j - int'(ptr) + N_CHANNELS) % N_CHANNELS;
      if (rdy[j] && d < best_d) begin
        best   = PTR_W'(j);
        best_d = d;
      end
    end
    return best;
  endfunction

  assign ptr_after = (int'(grant) == N_CHANNELS - 1) ? '0 : grant + 1'b1;
  assign pick_idle = pick(sample_rdy, rr_ptr);
  assign pick_next = pick(sample_rdy, ptr_after);
  assign tag_byte  = {5'b10100, 3'(grant)};

  always_comb begin
    slice = '0;
    for (int c = 0; c < N_CHANNELS; c++) begin
      if (grant == PTR_W'(c)) slice = sample[c*SW +: SW];
    end
  end

  generate
    if (TAG_EN != 0) begin : g_tag
      assign frame_new = {tag_byte, slice};
    end else begin : g_raw
      assign frame_new = slice;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      rr_ptr     <= '0;
      sample_req <= '0;
      data_rdy   <= 1'b0;
      data       <= 8'h00;
      channel    <= 3'd0;
      idx        <= '0;
      shadow     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|sample_rdy) begin
            grant      <= pick_idle;
            channel    <= 3'(pick_idle);
            sample_req <= N_CHANNELS'(1) << pick_idle;
            state      <= REQ;
          end
        end
        REQ: begin
          sample_req <= '0;
          state      <= LOAD;
        end
        LOAD: begin
          // FIFO word is valid now; everything after this comes from the shadow copy.
          data     <= frame_new[FW-1 -: 8];
          shadow   <= frame_new << 8;
          idx      <= '0;
          data_rdy <= 1'b1;
          state    <= SEND;
        end
        SEND: begin
          if (data_ack) begin
            if (idx != IDX_W'(FRAME_BYTES - 1)) begin
              idx    <= idx + 1'b1;
              data   <= shadow[FW-1 -: 8];
              shadow <= shadow << 8;
            end else begin
              rr_ptr   <= ptr_after;
              data_rdy <= 1'b0;
              data     <= 8'h00;
              if (|sample_rdy) begin
                grant      <= pick_next;
                channel    <= 3'(pick_next);
                sample_req <= N_CHANNELS'(1) << pick_next;
                state      <= REQ;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_serializer.sv
// Bench for sample_serializer: queue-based FIFO and byte-stream reference model on the default config,
// plus a directed tagged-frame run on a TAG_EN=1 instance.
module tb_sample_serializer;

  localparam int SB = 6;
  localparam int N  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [N*SB*8-1:0] sample_a;
  logic [N-1:0]     rdy_a, req_a;
  logic [7:0]       data_a;
  logic             drdy_a, ack_a;
  logic [2:0]       chan_a;

  logic [N*SB*8-1:0] sample_t;
  logic [N-1:0]     rdy_t, req_t;
  logic [7:0]       data_t;
  logic             drdy_t, ack_t;
  logic [2:0]       chan_t;

  sample_serializer #(.SAMPLE_BYTES(SB), .N_CHANNELS(N), .TAG_EN(0)) u_dut (
    .clk(clk), .reset(reset), .sample(sample_a), .sample_rdy(rdy_a), .sample_req(req_a),
    .data(data_a), .data_rdy(drdy_a), .data_ack(ack_a), .channel(chan_a)
  );

  sample_serializer #(.SAMPLE_BYTES(SB), .N_CHANNELS(N), .TAG_EN(1)) u_dut_tag (
    .clk(clk), .reset(reset), .sample(sample_t), .sample_rdy(rdy_t), .sample_req(req_t),
    .data(data_t), .data_rdy(drdy_t), .data_ack(ack_t), .channel(chan_t)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [47:0] q0[$];
  logic [47:0] q1[$];
  logic [7:0]  exp_q[$];
  int          grants[$];
  int          rr_m;
  logic [N-1:0] rdy_prev;
  int          hold_cnt;
  int          hold_ch;
  logic [47:0] hold_word;
  int          ack_mode;
  logic        rst_prev, drdy_prev, ack_prev;
  logic [7:0]  data_prev;
  int          last_req_cyc, last_rise_cyc, last_fall_cyc, last_final_cyc;
  int          expect_req_cyc, expect_noreq_cyc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Empty FIFO presents all-ones, so a late capture would show up as 0xFF bytes.
  function automatic logic [47:0] bus_word(input int c);
    if (hold_cnt > 0 && hold_ch == c) return hold_word;
    if (c == 0) return (q0.size() != 0) ? q0[0] : '1;
    return (q1.size() != 0) ? q1[0] : '1;
  endfunction

  function automatic int model_pick(input logic [N-1:0] rdy);
    for (int d = 0; d < N; d++) begin
      int c;
      c = (rr_m + d) % N;
      if (((rdy >> c) & N'(1)) != '0) return c;
    end
    return -1;
  endfunction

  task automatic push_frame(input logic [47:0] w);
    for (int b = SB - 1; b >= 0; b--) exp_q.push_back(w[b*8 +: 8]);
  endtask

  task automatic drive();
    sample_a = {bus_word(1), bus_word(0)};
    if (hold_cnt > 0) hold_cnt--;
    rdy_prev = rdy_a;
    rdy_a    = {q1.size() != 0, q0.size() != 0};
    ack_a    = (ack_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
  endtask

  task automatic monitor();
    int g;
    int c;
    if (reset) begin
      exp_q.delete();
      hold_cnt         = 0;
      rr_m             = 0;
      expect_req_cyc   = -1;
      expect_noreq_cyc = -1;
    end else begin
      if (rst_prev) begin
        check("rst_req", 64'(req_a), 64'(0));
        check("rst_data_rdy", 64'(drdy_a), 64'(0));
        check("rst_data", 64'(data_a), 64'(0));
        check("rst_channel", 64'(chan_a), 64'(0));
      end
      if (cyc == expect_req_cyc) check("b2b_req", 64'(req_a != 0), 64'(1));
      if (cyc == expect_noreq_cyc) check("idle_after_frame", 64'(req_a), 64'(0));
      if (req_a != 0) begin
        check("req_onehot", 64'($countones(req_a)), 64'(1));
        g = model_pick(rdy_prev);
        if (g < 0) begin
          check("req_spurious", 64'(req_a), 64'(0));
        end else begin
          check("grant", 64'(req_a), 64'(N'(1) << g));
          check("channel", 64'(chan_a), 64'(g));
          grants.push_back(g);
          rr_m = (g + 1) % N;
        end
        c = req_a[1] ? 1 : 0;
        if (c == 0) hold_word = (q0.size() != 0) ? q0.pop_front() : '1;
        else        hold_word = (q1.size() != 0) ? q1.pop_front() : '1;
        hold_ch  = c;
        hold_cnt = 1;
        push_frame(hold_word);
        last_req_cyc = cyc;
      end
      if (drdy_a && !drdy_prev) begin
        last_rise_cyc = cyc;
        check("req_to_data", 64'(cyc - last_req_cyc), 64'(2));
      end
      if (!drdy_a && drdy_prev) last_fall_cyc = cyc;
      if (!drdy_a) check("data_idle_zero", 64'(data_a), 64'(0));
      if (drdy_prev && !ack_prev && !rst_prev) begin
        check("stall_rdy", 64'(drdy_a), 64'(1));
        check("stall_data", 64'(data_a), 64'(data_prev));
      end
      if (drdy_a && grants.size() != 0) check("chan_in_frame", 64'(chan_a), 64'(grants[$]));
      if (drdy_a && ack_a) begin
        if (exp_q.size() == 0) begin
          check("byte_pending", 64'(exp_q.size()), 64'(1));
        end else begin
          check("byte", 64'(data_a), 64'(exp_q.pop_front()));
          if (exp_q.size() == 0) begin
            last_final_cyc = cyc;
            if (rdy_a != 0) expect_req_cyc = cyc + 1;
            else            expect_noreq_cyc = cyc + 1;
          end
        end
      end
    end
    rst_prev  = reset;
    drdy_prev = drdy_a;
    ack_prev  = ack_a;
    data_prev = data_a;
  endtask

  task automatic tick();
    drive();
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while (n < max && !(q0.size() == 0 && q1.size() == 0 && exp_q.size() == 0 &&
                        hold_cnt == 0 && !drdy_a && req_a == 0)) begin
      tick();
      n++;
    end
    check("drain_pending", 64'(exp_q.size() + q0.size() + q1.size()), 64'(0));
    tick();
    tick();
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int k;
    int n;
    int got;
    logic [7:0]  exp_t[$];
    logic [47:0] w;

    reset = 1'b1;
    sample_a = '0; rdy_a = '0; ack_a = 1'b0;
    sample_t = '0; rdy_t = '0; ack_t = 1'b0;
    rr_m = 0; hold_cnt = 0; hold_ch = 0; hold_word = '0; ack_mode = 0;
    rst_prev = 1'b0; drdy_prev = 1'b0; ack_prev = 1'b0; data_prev = '0; rdy_prev = '0;
    last_req_cyc = -100; last_rise_cyc = -100; last_fall_cyc = -100; last_final_cyc = -100;
    expect_req_cyc = -1; expect_noreq_cyc = -1;

    tick();
    reset_pulse();

    // Single ch0 frame, ack held high; FIFO shows all-ones once popped.
    ack_mode = 0;
    k = cyc;
    q0.push_back(48'h0102_0304_0506);
    drain(60);
    check("t1_req_cycle", 64'(last_req_cyc - k), 64'(1));
    check("t1_first_data", 64'(last_rise_cyc - k), 64'(3));
    check("t1_last_ack", 64'(last_final_cyc - k), 64'(8));
    check("t1_idle", 64'(last_fall_cyc - k), 64'(9));

    // Both channels busy for four frames straight after reset.
    reset_pulse();
    grants.delete();
    for (int i = 0; i < 2; i++) begin
      q0.push_back({16'($urandom), $urandom});
      q1.push_back({16'($urandom), $urandom});
    end
    drain(200);
    check("rr_count", 64'(grants.size()), 64'(4));
    for (int i = 0; i < 4 && i < grants.size(); i++) check("rr_order", 64'(grants[i]), 64'(i % 2));

    // Random arrivals with ~50% ack stalls, including acks while idle.
    ack_mode = 1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        w = {16'($urandom), $urandom};
        if ($urandom_range(0, 1) == 0) begin
          if (q0.size() < 3) q0.push_back(w);
        end else begin
          if (q1.size() < 3) q1.push_back(w);
        end
      end
      tick();
    end
    drain(3000);

    // Reset while the third byte of a ch1 frame is on the bus.
    ack_mode = 0;
    q1.push_back(48'h1112_1314_1516);
    n = 0;
    while (n < 40 && !(drdy_a && exp_q.size() == SB - 2)) begin
      tick();
      n++;
    end
    check("abort_point", 64'(exp_q.size()), 64'(SB - 2));
    check("abort_channel", 64'(chan_a), 64'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    grants.delete();
    q1.push_back(48'h2122_2324_2526);
    q0.push_back(48'h3132_3334_3536);
    drain(100);
    check("post_reset_count", 64'(grants.size()), 64'(2));
    if (grants.size() == 2) begin
      check("post_reset_first", 64'(grants[0]), 64'(0));
      check("post_reset_second", 64'(grants[1]), 64'(1));
    end

    // Tagged frame from channel 1 on the TAG_EN=1 instance.
    w = 48'hAABB_CCDD_EEFF;
    exp_t.push_back(8'hA0 | 8'd1);
    for (int b = SB - 1; b >= 0; b--) exp_t.push_back(w[b*8 +: 8]);
    sample_t[2*48-1:48] = w;
    rdy_t = 2'b10;
    ack_t = 1'b1;
    got = 0;
    for (int i = 0; i < 40 && got < SB + 1; i++) begin
      @(posedge clk);
      #1;
      if (req_t != 0) begin
        check("tag_req", 64'(req_t), 64'(2'b10));
        rdy_t = '0;
      end
      if (drdy_t && ack_t) begin
        check("tag_byte", 64'(data_t), 64'(exp_t[got]));
        check("tag_chan", 64'(chan_t), 64'(1));
        got++;
      end
    end
    check("tag_bytes_seen", 64'(got), 64'(SB + 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
